mixcol_sequencer: RTL and testbench
===================================

MIXCOL_SEQUENCER -- requirements
Module: mixcol_sequencer

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 ClkxCI  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 RstxBI  in  1  asynchronous, active-low reset.
REQ-004 StartxSI  in  1  start request; accepted only when ReadyxSO=1.
REQ-005 BypassxSI  in  1  sampled with an accepted start; 1 = final round, columns copied unchanged.
REQ-006 AbortxSI  in  1  synchronous abort of a running operation.
REQ-007 StatexDI  in  128  input state; column c = bits [127-32c : 96-32c]; byte 0 of a column = its most significant byte.
REQ-008 ReadyxSO  out  1  block can accept a start this cycle.
REQ-009 BusyxSO  out  1  a column operation is in progress.
REQ-010 DonexSO  out  1  one-cycle pulse: StatexDO holds a complete result.
REQ-011 StatexDO  out  128  state register, using the same column and byte layout as StatexDI.

Function
REQ-012 The block SHALL contain exactly one MixColumns column datapath (4 bytes in, 4 bytes out, GF(2^8) with polynomial 0x11B) and SHALL time-share it over the four columns.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE: ReadyxSO=1, BusyxSO=0, DonexSO=0.
REQ-015 When StartxSI=1 and ReadyxSO=1, the block SHALL load StatexDI into the state register, latch BypassxSI into a bypass flag, clear the 2-bit column counter, and go to RUN.
REQ-016 RUN: BusyxSO=1 and ReadyxSO=0.
REQ-017 In each RUN cycle with counter value c, the block SHALL write column c back in place: the MixColumns result if bypass=0, or the unchanged column if bypass=1.
REQ-018 In RUN, the counter SHALL increment by 1 each cycle; after the cycle that writes c=3, the FSM SHALL go to DONE.
REQ-019 Latency: for a start accepted at edge t, columns 0..3 are written at edges t+1..t+4, and DonexSO=1 during the cycle after edge t+4 (exactly 4 cycles of BusyxSO).
REQ-020 DONE: DonexSO=1 for exactly one cycle, ReadyxSO=1, BusyxSO=0.
REQ-021 From DONE, the FSM SHALL go to RUN if a start is accepted in that cycle, else to IDLE; this allows back-to-back operation with 5 cycles per state.
REQ-022 StatexDO SHALL hold the completed result from DONE until the edge that accepts the next start; the consumer captures it while DonexSO=1.
REQ-023 StartxSI SHALL be ignored while in RUN; the state register, counter and bypass flag are unaffected.
REQ-024 AbortxSI=1 in RUN SHALL return the FSM to IDLE at the next edge with no DonexSO pulse; columns already written remain in the register.
REQ-025 AbortxSI=1 in IDLE or DONE SHALL have no effect; start acceptance in DONE takes priority over abort.
REQ-026 The column counter SHALL wrap 3->0 only via a new start; it never wraps inside RUN.
REQ-027 Intermediate StatexDO values during RUN are undefined for the consumer and SHALL NOT be qualified by any output.

Reset
REQ-028 When RstxBI=0, the block SHALL immediately enter IDLE, clear the state register to 128'h0, the counter to 0 and the bypass flag to 0, and drive ReadyxSO=1, BusyxSO=0, DonexSO=0.
REQ-029 A reset asserted during RUN or DONE SHALL discard the operation with no DonexSO pulse; the first start after deassertion is accepted normally.

Verification
REQ-030 Start with StatexDI = db135345_f20a225c_01010101_c6c6c6c6 and Bypass=0 -> after 4 Busy cycles, DonexSO pulses with StatexDO = 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
REQ-031 Start with StatexDI = d4d4d4d5_2d26314c_00000000_ffffffff and Bypass=1 -> DonexSO at the same latency; StatexDO equals the input unchanged.
REQ-032 Start with StatexDI = d4d4d4d5_2d26314c_00000000_ffffffff and Bypass=0 -> StatexDO = d5d5d7d6_4d7ebdf8_00000000_ffffffff.
REQ-033 Back-to-back: assert StartxSI during DONE with new data -> BusyxSO goes high on the next cycle; the second DonexSO pulse arrives exactly 5 cycles after the first, with the correct result.
REQ-034 StartxSI pulsed in the second RUN cycle, and AbortxSI pulsed in the third RUN cycle of another operation -> the start is ignored; after the abort the FSM is in IDLE, DonexSO is never asserted, and ReadyxSO=1.
REQ-035 RstxBI driven low asynchronously (mid-cycle) during RUN -> outputs go immediately to StatexDO=0, ReadyxSO=1, BusyxSO=0 with no DonexSO pulse; after release, the operation from REQ-030 completes correctly.

Source files
------------

// File: rtl/mixcol_sequencer.sv
// Time-shared MixColumns over a 128-bit state: one column per cycle, Done 5 cycles after start.
// No backpressure: Ready high in IDLE/DONE, starts during RUN are dropped; Abort returns to IDLE.
module mixcol_sequencer (
  input  logic         ClkxCI,
  input  logic         RstxBI,
  input  logic         StartxSI,
  input  logic         BypassxSI,
  input  logic         AbortxSI,
  input  logic [127:0] StatexDI,
  output logic         ReadyxSO,
  output logic         BusyxSO,
  output logic         DonexSO,
  output logic [127:0] StatexDO
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic         bypass_q;
  logic [127:0] state_reg_q;
  logic         start_acc;
  logic         col_wr;

  logic [31:0]  col_in, col_out;
  logic [7:0]   b0, b1, b2, b3;
  logic [7:0]   x0, x1, x2, x3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    col_in = state_reg_q[127:96];
    case (col_q)
      2'd0:    col_in = state_reg_q[127:96];
      2'd1:    col_in = state_reg_q[95:64];
      2'd2:    col_in = state_reg_q[63:32];
      default: col_in = state_reg_q[31:0];
    endcase
  end

  // Byte 0 is the most significant byte of the column.
  assign b0 = col_in[31:24];
  assign b1 = col_in[23:16];
  assign b2 = col_in[15:8];
  assign b3 = col_in[7:0];
  assign x0 = xtime(b0);
  assign x1 = xtime(b1);
  assign x2 = xtime(b2);
  assign x3 = xtime(b3);

  assign col_out = bypass_q ? col_in :
                   {x0 ^ x1 ^ b1 ^ b2 ^ b3,
                    b0 ^ x1 ^ x2 ^ b2 ^ b3,
                    b0 ^ b1 ^ x2 ^ x3 ^ b3,
                    x0 ^ b0 ^ b1 ^ b2 ^ x3};

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    ReadyxSO  = 1'b0;
    BusyxSO   = 1'b0;
    DonexSO   = 1'b0;
    col_wr    = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        ReadyxSO = 1'b1;
        if (StartxSI) begin
          start_acc = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        BusyxSO = 1'b1;
        if (AbortxSI) begin
          state_d = IDLE;
        end else begin
          col_wr = 1'b1;
          if (col_q == 2'd3) state_d = DONE;
          else               col_d   = col_q + 2'd1;
        end
      end
      DONE: begin
        ReadyxSO = 1'b1;
        DonexSO  = 1'b1;
        if (StartxSI) begin
          start_acc = 1'b1;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_acc) col_d = 2'd0;
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_reg_q <= 128'h0;
      bypass_q    <= 1'b0;
    end else if (start_acc) begin
      state_reg_q <= StatexDI;
      bypass_q    <= BypassxSI;
    end else if (col_wr) begin
      case (col_q)
        2'd0:    state_reg_q[127:96] <= col_out;
        2'd1:    state_reg_q[95:64]  <= col_out;
        2'd2:    state_reg_q[63:32]  <= col_out;
        default: state_reg_q[31:0]   <= col_out;
      endcase
    end
  end

  assign StatexDO = state_reg_q;

endmodule

// File: tb/tb_mixcol_sequencer.sv
// Directed bench for mixcol_sequencer: known MixColumns vectors, latency, back-to-back, abort, async reset.
module tb_mixcol_sequencer;

  logic         ClkxCI;
  logic         RstxBI;
  logic         StartxSI;
  logic         BypassxSI;
  logic         AbortxSI;
  logic [127:0] StatexDI;
  logic         ReadyxSO;
  logic         BusyxSO;
  logic         DonexSO;
  logic [127:0] StatexDO;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] E2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  mixcol_sequencer dut (
    .ClkxCI   (ClkxCI),
    .RstxBI   (RstxBI),
    .StartxSI (StartxSI),
    .BypassxSI(BypassxSI),
    .AbortxSI (AbortxSI),
    .StatexDI (StatexDI),
    .ReadyxSO (ReadyxSO),
    .BusyxSO  (BusyxSO),
    .DonexSO  (DonexSO),
    .StatexDO (StatexDO)
  );

  initial ClkxCI = 1'b0;
  always #5 ClkxCI = ~ClkxCI;

  // Presents a start for one edge; returns sampled just after the accepting edge.
  task automatic start_op(input logic [127:0] d, input logic byp);
    StartxSI  = 1'b1;
    BypassxSI = byp;
    StatexDI  = d;
    @(posedge ClkxCI); #1;
    StartxSI  = 1'b0;
    BypassxSI = 1'b0;
  endtask

  // Steps until Done is seen (bounded); busy_n includes the current sample.
  task automatic wait_done(output int edges, output int busy_n, output bit seen);
    edges  = 0;
    seen   = 1'b0;
    busy_n = BusyxSO ? 1 : 0;
    while (!seen && edges < 20) begin
      @(posedge ClkxCI); #1;
      edges++;
      if (DonexSO) seen = 1'b1;
      else if (BusyxSO) busy_n++;
    end
  endtask

  task automatic test_reset;
    RstxBI = 1'b0; StartxSI = 1'b0; BypassxSI = 1'b0; AbortxSI = 1'b0; StatexDI = V1;
    #2;
    n_checks++; if (ReadyxSO !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ReadyxSO); end
    n_checks++; if (BusyxSO !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BusyxSO); end
    n_checks++; if (DonexSO !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", DonexSO); end
    n_checks++; if (StatexDO !== 128'h0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", StatexDO); end
    @(posedge ClkxCI); #1;
    RstxBI = 1'b1;
    @(posedge ClkxCI); #1;
    n_checks++; if (ReadyxSO !== 1'b1 || BusyxSO !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: ready %b busy %b expected 1 0", ReadyxSO, BusyxSO); end
  endtask

  task automatic test_mix;
    int e, b; bit s;
    start_op(V1, 1'b0);
    n_checks++; if (BusyxSO !== 1'b1 || ReadyxSO !== 1'b0) begin n_fail++; $display("FAIL mix_run_flags: busy %b ready %b expected 1 0", BusyxSO, ReadyxSO); end
    wait_done(e, b, s);
    n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL mix_done_seen: got %b expected 1", s); end
    n_checks++; if (e != 4) begin n_fail++; $display("FAIL mix_latency: got %0d expected 4", e); end
    n_checks++; if (b != 4) begin n_fail++; $display("FAIL mix_busy_cycles: got %0d expected 4", b); end
    n_checks++; if (StatexDO !== E1) begin n_fail++; $display("FAIL mix_result: got %h expected %h", StatexDO, E1); end
    n_checks++; if (ReadyxSO !== 1'b1 || BusyxSO !== 1'b0) begin n_fail++; $display("FAIL mix_done_flags: ready %b busy %b expected 1 0", ReadyxSO, BusyxSO); end
    @(posedge ClkxCI); #1;
    n_checks++; if (DonexSO !== 1'b0) begin n_fail++; $display("FAIL mix_done_pulse: got %b expected 0", DonexSO); end
    n_checks++; if (StatexDO !== E1) begin n_fail++; $display("FAIL mix_hold: got %h expected %h", StatexDO, E1); end
  endtask

  task automatic test_bypass;
    int e, b; bit s;
    start_op(V2, 1'b1);
    wait_done(e, b, s);
    n_checks++; if (s !== 1'b1 || e != 4) begin n_fail++; $display("FAIL byp_latency: seen %b edges %0d expected 1 4", s, e); end
    n_checks++; if (StatexDO !== V2) begin n_fail++; $display("FAIL byp_result: got %h expected %h", StatexDO, V2); end
    @(posedge ClkxCI); #1;
  endtask

  task automatic test_mix2;
    int e, b; bit s;
    start_op(V2, 1'b0);
    wait_done(e, b, s);
    n_checks++; if (s !== 1'b1 || e != 4) begin n_fail++; $display("FAIL mix2_latency: seen %b edges %0d expected 1 4", s, e); end
    n_checks++; if (StatexDO !== E2) begin n_fail++; $display("FAIL mix2_result: got %h expected %h", StatexDO, E2); end
    @(posedge ClkxCI); #1;
  endtask

  task automatic test_back_to_back;
    int e, b; bit s;
    start_op(V1, 1'b0);
    wait_done(e, b, s);
    n_checks++; if (s !== 1'b1 || StatexDO !== E1) begin n_fail++; $display("FAIL b2b_first: seen %b state %h expected 1 %h", s, StatexDO, E1); end
    start_op(V2, 1'b0);
    n_checks++; if (BusyxSO !== 1'b1 || DonexSO !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: busy %b done %b expected 1 0", BusyxSO, DonexSO); end
    wait_done(e, b, s);
    n_checks++; if (s !== 1'b1 || e + 1 != 5) begin n_fail++; $display("FAIL b2b_gap: seen %b gap %0d expected 1 5", s, e + 1); end
    n_checks++; if (b != 4) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 4", b); end
    n_checks++; if (StatexDO !== E2) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", StatexDO, E2); end
    @(posedge ClkxCI); #1;
  endtask

  task automatic test_start_ignored_abort;
    int e, b; bit s; int done_n;
    start_op(V1, 1'b0);
    @(posedge ClkxCI); #1;
    StartxSI = 1'b1; StatexDI = V2; BypassxSI = 1'b1;
    @(posedge ClkxCI); #1;
    StartxSI = 1'b0; BypassxSI = 1'b0;
    n_checks++; if (BusyxSO !== 1'b1 || ReadyxSO !== 1'b0) begin n_fail++; $display("FAIL ign_still_run: busy %b ready %b expected 1 0", BusyxSO, ReadyxSO); end
    wait_done(e, b, s);
    n_checks++; if (s !== 1'b1 || e != 2) begin n_fail++; $display("FAIL ign_latency: seen %b edges %0d expected 1 2", s, e); end
    n_checks++; if (StatexDO !== E1) begin n_fail++; $display("FAIL ign_result: got %h expected %h", StatexDO, E1); end
    @(posedge ClkxCI); #1;
    start_op(V2, 1'b0);
    @(posedge ClkxCI); #1;
    @(posedge ClkxCI); #1;
    AbortxSI = 1'b1;
    @(posedge ClkxCI); #1;
    AbortxSI = 1'b0;
    n_checks++; if (ReadyxSO !== 1'b1 || BusyxSO !== 1'b0 || DonexSO !== 1'b0) begin n_fail++; $display("FAIL abort_idle: ready %b busy %b done %b expected 1 0 0", ReadyxSO, BusyxSO, DonexSO); end
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge ClkxCI); #1;
      if (DonexSO) done_n++;
    end
    n_checks++; if (done_n != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_n); end
    n_checks++; if (ReadyxSO !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", ReadyxSO); end
  endtask

  task automatic test_async_reset;
    int e, b; bit s; int done_n;
    start_op(V1, 1'b0);
    @(posedge ClkxCI); #3;
    RstxBI = 1'b0;
    #1;
    n_checks++; if (StatexDO !== 128'h0) begin n_fail++; $display("FAIL arst_state: got %h expected 0", StatexDO); end
    n_checks++; if (ReadyxSO !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b expected 1", ReadyxSO); end
    n_checks++; if (BusyxSO !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", BusyxSO); end
    n_checks++; if (DonexSO !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %b expected 0", DonexSO); end
    @(posedge ClkxCI); #1;
    RstxBI = 1'b1;
    done_n = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge ClkxCI); #1;
      if (DonexSO) done_n++;
    end
    n_checks++; if (done_n != 0) begin n_fail++; $display("FAIL arst_no_done: got %0d pulses expected 0", done_n); end
    start_op(V1, 1'b0);
    wait_done(e, b, s);
    n_checks++; if (s !== 1'b1 || e != 4) begin n_fail++; $display("FAIL arst_rerun_latency: seen %b edges %0d expected 1 4", s, e); end
    n_checks++; if (StatexDO !== E1) begin n_fail++; $display("FAIL arst_rerun_result: got %h expected %h", StatexDO, E1); end
    @(posedge ClkxCI); #1;
  endtask

  initial begin
    test_reset();
    test_mix();
    test_bypass();
    test_mix2();
    test_back_to_back();
    test_start_ignored_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
